// File: rtl/fpu_div_arbiter_if.sv
// ---------------------------------------------------------------------------
// fpu_div_arbiter_if : shared types plus requester/response/divider bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fpu_div_arbiter_pkg;
  typedef logic [15:0] fp16_t;
  typedef logic [3:0]  condCode_t;
  typedef logic [4:0]  opStatusFlag_t;
endpackage

interface fpu_div_arbiter_if
  import fpu_div_arbiter_pkg::*;
#(
  parameter type FP_T    = fp16_t,
  parameter int  NUM_REQ = 4
);
  logic [NUM_REQ-1:0]  reqValid;
  logic [NUM_REQ-1:0]  reqReady;
  FP_T  [NUM_REQ-1:0]  reqIn1;
  FP_T  [NUM_REQ-1:0]  reqIn2;
  logic [NUM_REQ-1:0]  respValid;
  logic [NUM_REQ-1:0]  respReady;
  FP_T                 respOut;
  condCode_t           respCondCodes;
  opStatusFlag_t       respFlags;
  logic                respTimeout;
  logic                busy;
  FP_T                 divIn1;
  FP_T                 divIn2;
  logic                divStart;
  logic                divAbort;
  FP_T                 divOut;
  logic                divDone;
  condCode_t           divCondCodes;
  opStatusFlag_t       divFlags;

  // Arbiter side
  modport master (
    input  reqValid, reqIn1, reqIn2, respReady,
           divOut, divDone, divCondCodes, divFlags,
    output reqReady, respValid, respOut, respCondCodes, respFlags, respTimeout,
           busy, divIn1, divIn2, divStart, divAbort
  );

  // Requesters and divider side
  modport slave (
    output reqValid, reqIn1, reqIn2, respReady,
           divOut, divDone, divCondCodes, divFlags,
    input  reqReady, respValid, respOut, respCondCodes, respFlags, respTimeout,
           busy, divIn1, divIn2, divStart, divAbort
  );
endinterface

`default_nettype wire

// File: rtl/fpu_div_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_div_arbiter : round-robin sharing of one multi-cycle divider among
// NUM_REQ requesters. Optional watchdog: FPU_DIV_ARB_TIMEOUT_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fpu_div_arbiter
  import fpu_div_arbiter_pkg::*;
#(
  parameter type FP_T           = fp16_t,
  parameter int  NUM_REQ        = 4,
  parameter int  TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              resetN,
  fpu_div_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CW    = IDX_W + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fpu_div_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fpu_div_arbiter: TIMEOUT_CYCLES must be positive");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    grant;
  logic [IDX_W-1:0]    last_grant;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_found;
  logic [NUM_REQ-1:0]  req_ready;
  logic [NUM_REQ-1:0]  resp_valid;
  logic                div_start;
  FP_T                 div_in1;
  FP_T                 div_in2;
  FP_T                 resp_out;
  condCode_t           resp_cc;
  opStatusFlag_t       resp_flags;

  // Search starts just after the last served requester so it ends up lowest.
  always_comb begin : rr_pick
    logic [CW-1:0] cand;
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + CW'(k);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!pick_found && bus.reqValid[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

`ifdef FPU_DIV_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;
  logic             div_abort;
  logic             resp_timeout;
`endif

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin : fsm_next
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = '0;
    div_start  = 1'b0;
`ifdef FPU_DIV_ARB_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          req_ready[pick_idx] = 1'b1;
          state_nxt           = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        div_start = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.divDone) begin
          state_nxt = ST_RESP;
        end
`ifdef FPU_DIV_ARB_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        resp_valid[grant] = 1'b1;
        if (bus.respReady[grant]) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      grant      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      div_in1    <= '0;
      div_in2    <= '0;
      resp_out   <= '0;
      resp_cc    <= '0;
      resp_flags <= '0;
`ifdef FPU_DIV_ARB_TIMEOUT_EN
      resp_timeout <= 1'b0;
`endif
    end else begin
      if (state == ST_IDLE && pick_found) begin
        grant   <= pick_idx;
        div_in1 <= bus.reqIn1[pick_idx];
        div_in2 <= bus.reqIn2[pick_idx];
      end
      if (state == ST_WAIT) begin
        if (bus.divDone) begin
          resp_out   <= bus.divOut;
          resp_cc    <= bus.divCondCodes;
          resp_flags <= bus.divFlags;
`ifdef FPU_DIV_ARB_TIMEOUT_EN
          resp_timeout <= 1'b0;
        end else if (timeout_hit) begin
          resp_out     <= '0;
          resp_cc      <= '0;
          resp_flags   <= '0;
          resp_timeout <= 1'b1;
`endif
        end
      end
      if (state == ST_RESP && bus.respReady[grant]) begin
        last_grant <= grant;
      end
    end
  end

`ifdef FPU_DIV_ARB_TIMEOUT_EN
  // Counter is zeroed in ISSUE so the first WAIT cycle sees 0.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wait_cnt  <= '0;
      div_abort <= 1'b0;
    end else begin
      div_abort <= timeout_hit;
      if (state == ST_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign bus.divAbort    = div_abort;
  assign bus.respTimeout = resp_timeout;
`else
  assign bus.divAbort    = 1'b0;
  assign bus.respTimeout = 1'b0;
`endif

  assign bus.reqReady      = req_ready;
  assign bus.respValid     = resp_valid;
  assign bus.respOut       = resp_out;
  assign bus.respCondCodes = resp_cc;
  assign bus.respFlags     = resp_flags;
  assign bus.busy          = (state != ST_IDLE);
  assign bus.divIn1        = div_in1;
  assign bus.divIn2        = div_in2;
  assign bus.divStart      = div_start;

endmodule

`default_nettype wire

// File: tb/tb_fpu_div_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpu_div_arbiter : scoreboard bench with a transaction-level arbiter
// model and a behavioural fp16 divider. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fpu_div_arbiter;
  import fpu_div_arbiter_pkg::*;

  localparam int NR = 4;

  typedef struct packed {
    logic [2:0]  g;
    logic [15:0] q;
    logic [3:0]  cc;
    logic [4:0]  fl;
    logic        to;
  } resp_t;

  logic clock;
  logic resetN;

  fpu_div_arbiter_if #(.FP_T(fp16_t), .NUM_REQ(NR)) bus ();

  fpu_div_arbiter #(.FP_T(fp16_t), .NUM_REQ(NR), .TIMEOUT_CYCLES(64)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  int      n_checks = 0;
  int      n_fail   = 0;
  resp_t   sb[$];
  int      last_m   = NR - 1;
  bit      busy_m   = 1'b0;
  bit      issue_due = 1'b0;
  logic [NR-1:0] accepted = '0;
  int      fixed_lat = 0;
  bit      keep_all  = 1'b0;
  bit      rand_req  = 1'b0;
  bit      rr_random = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expire(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Plain fp16 quotient (truncating), used both as the divider and as the reference.
  function automatic resp_t ref_div(logic [15:0] a, logic [15:0] b);
    resp_t r;
    int ea, eb, e;
    int unsigned ma, mb, q, rem;
    logic s;
    r  = '0;
    s  = a[15] ^ b[15];
    ea = {27'd0, a[14:10]};
    eb = {27'd0, b[14:10]};
    if (ea == 31 || eb == 31 || (ea == 0 && eb == 0)) begin
      r.q = 16'h7E00; r.fl = 5'b10000;
    end else if (eb == 0) begin
      r.q = {s, 5'h1F, 10'h000}; r.fl = 5'b01000;
    end else if (ea == 0) begin
      r.q = {s, 15'h0000};
    end else begin
      ma  = {21'd0, 1'b1, a[9:0]};
      mb  = {21'd0, 1'b1, b[9:0]};
      q   = (ma << 10) / mb;
      rem = (ma << 10) % mb;
      e   = ea - eb + 15;
      if (q < 1024) begin
        q   = (ma << 11) / mb;
        rem = (ma << 11) % mb;
        e   = e - 1;
      end
      if (e >= 31) begin
        r.q = {s, 5'h1F, 10'h000}; r.fl = 5'b00101;
      end else if (e <= 0) begin
        r.q = {s, 15'h0000}; r.fl = 5'b00011;
      end else begin
        r.q = {s, e[4:0], q[9:0]}; r.fl = {4'b0000, rem != 0};
      end
    end
    r.cc = {r.q[15], r.q[14:0] == 15'd0,
            r.q[14:10] == 5'h1F && r.q[9:0] == 10'd0,
            r.q[14:10] == 5'h1F && r.q[9:0] != 10'd0};
    return r;
  endfunction

  function automatic int pick(logic [NR-1:0] v, int last);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  // Divider model plus scoreboard monitor, all sampled on the falling edge.
  initial begin : monitor
    logic [15:0] cap1, cap2;
    int    dcnt;
    int    g;
    resp_t e;
    bus.divDone      = 1'b0;
    bus.divOut       = '0;
    bus.divCondCodes = '0;
    bus.divFlags     = '0;
    dcnt = 0;
    cap1 = '0;
    cap2 = '0;
    forever begin
      @(negedge clock);
      accepted     = '0;
      bus.divDone  = 1'b0;
      bus.divOut       = 16'($urandom);
      bus.divCondCodes = 4'($urandom);
      bus.divFlags     = 5'($urandom);
      if (!resetN) begin
        dcnt = 0; sb.delete(); last_m = NR - 1; busy_m = 0; issue_due = 0;
        continue;
      end
      if (bus.divStart) begin
        cap1 = bus.divIn1;
        cap2 = bus.divIn2;
        dcnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
      end else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          chk("div_operands_stable", {bus.divIn1, bus.divIn2}, {cap1, cap2});
          e = ref_div(cap1, cap2);
          bus.divOut       = e.q;
          bus.divCondCodes = e.cc;
          bus.divFlags     = e.fl;
          bus.divDone      = 1'b1;
        end
      end

      chk("busy", 32'(bus.busy), 32'(busy_m));
      chk("div_start", 32'(bus.divStart), 32'(issue_due));
      chk("div_abort", 32'(bus.divAbort), 32'd0);
      issue_due = 1'b0;

      if (!busy_m && bus.reqValid != '0) begin
        g = pick(bus.reqValid, last_m);
        chk("req_ready_grant", 32'(bus.reqReady), 32'd1 << g);
        e      = ref_div(bus.reqIn1[g], bus.reqIn2[g]);
        e.g    = 3'(g);
        e.to   = 1'b0;
        sb.push_back(e);
        busy_m    = 1'b1;
        issue_due = 1'b1;
        accepted  = bus.reqReady;
      end else begin
        chk("req_ready_quiet", 32'(bus.reqReady), 32'd0);
      end

      if (bus.respValid != '0) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 32'(bus.respValid), 32'd0);
        end else begin
          e = sb[0];
          chk("resp_valid", 32'(bus.respValid), 32'd1 << e.g);
          chk("resp_out", 32'(bus.respOut), 32'(e.q));
          chk("resp_cc", 32'(bus.respCondCodes), 32'(e.cc));
          chk("resp_flags", 32'(bus.respFlags), 32'(e.fl));
          chk("resp_timeout", 32'(bus.respTimeout), 32'(e.to));
          if (bus.respReady[e.g]) begin
            void'(sb.pop_front());
            last_m = int'(e.g);
            busy_m = 1'b0;
          end
        end
      end
    end
  end

  task automatic new_req(int i);
    bus.reqValid[i] = 1'b1;
    bus.reqIn1[i]   = 16'($urandom);
    bus.reqIn2[i]   = 16'($urandom);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (accepted[i]) begin
        bus.reqValid[i] = 1'b0;
        if (keep_all) new_req(i);
      end else if (rand_req) begin
        if (!bus.reqValid[i] && $urandom_range(0, 3) == 0) new_req(i);
        else if (bus.reqValid[i] && $urandom_range(0, 29) == 0) bus.reqValid[i] = 1'b0;
      end
    end
    if (rr_random) bus.respReady = NR'($urandom);
  endtask

  task automatic drain(int maxc);
    int n = 0;
    rand_req = 0; keep_all = 0; rr_random = 0;
    bus.respReady = '1;
    while ((bus.busy || bus.reqValid != '0 || sb.size() != 0) && n < maxc) begin
      step();
      n++;
    end
    if (bus.busy || bus.reqValid != '0 || sb.size() != 0) expire("drain");
  endtask

  task automatic wait_resp(int i, int maxc);
    int n = 0;
    while (!bus.respValid[i] && n < maxc) begin
      step();
      n++;
    end
    if (!bus.respValid[i]) expire($sformatf("wait_resp_%0d", i));
  endtask

  task automatic wait_grant(int maxc);
    int n = 0;
    while (bus.reqReady == '0 && n < maxc) begin
      step();
      n++;
    end
    if (bus.reqReady == '0) expire("wait_grant");
  endtask

  task automatic reset_pulse();
    @(posedge clock);
    #1;
    resetN = 1'b0;
    bus.reqValid = '0;
    repeat (2) @(posedge clock);
    #1;
    resetN = 1'b1;
  endtask

  initial begin : stimulus
    logic [15:0] saved;
    int n;
    resetN        = 1'b0;
    bus.reqValid  = '0;
    bus.reqIn1    = '0;
    bus.reqIn2    = '0;
    bus.respReady = '1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_req_ready", 32'(bus.reqReady), 32'd0);
    chk("reset_resp_valid", 32'(bus.respValid), 32'd0);
    chk("reset_resp_out", 32'(bus.respOut), 32'd0);
    chk("reset_div_start", 32'(bus.divStart), 32'd0);
    chk("reset_div_in", {bus.divIn1, bus.divIn2}, 32'd0);
    resetN = 1'b1;

    // Single requests with known quotients
    bus.reqValid[0] = 1'b1; bus.reqIn1[0] = 16'h3C00; bus.reqIn2[0] = 16'h4000;
    #1;
    chk("single_req_ready", 32'(bus.reqReady), 32'h1);
    step();
    chk("single_div_start", 32'(bus.divStart), 32'd1);
    chk("single_busy", 32'(bus.busy), 32'd1);
    wait_resp(0, 30);
    chk("single_resp_out0", 32'(bus.respOut), 32'h3800);
    drain(50);
    bus.reqValid[2] = 1'b1; bus.reqIn1[2] = 16'h4400; bus.reqIn2[2] = 16'h4000;
    wait_resp(2, 30);
    chk("single_resp_out2", 32'(bus.respOut), 32'h4000);
    drain(50);

    // All requesters continuously valid right after reset
    reset_pulse();
    for (int i = 0; i < NR; i++) new_req(i);
    bus.reqIn1[0] = 16'h8FE3; bus.reqIn2[0] = 16'hA3CC;
    keep_all = 1;
    repeat (60) step();
    drain(100);

    // Backpressure on requester 1 with others waiting
    bus.respReady = 4'b1101;
    new_req(1);
    wait_resp(1, 40);
    saved = bus.respOut;
    new_req(0); new_req(2); new_req(3);
    repeat (10) begin
      step();
      chk("bp_hold_valid", 32'(bus.respValid), 32'h2);
      chk("bp_no_ready", 32'(bus.reqReady), 32'd0);
      chk("bp_out_stable", 32'(bus.respOut), 32'(saved));
      chk("bp_no_start", 32'(bus.divStart), 32'd0);
    end
    drain(200);

    // Requester 1 re-requests right after completing while 3 waits
    new_req(1);
    wait_resp(1, 40);
    new_req(1); new_req(3);
    wait_grant(5);
    chk("rerequest_grant", 32'(bus.reqReady), 32'h8);
    drain(100);

    // Reset in the middle of WAIT
    fixed_lat = 20;
    new_req(2);
    n = 0;
    while (!bus.divStart && n < 10) begin step(); n++; end
    if (!bus.divStart) expire("wait_div_start");
    repeat (3) step();
    resetN = 1'b0;
    bus.reqValid = '0;
    #1;
    chk("midreset_busy", 32'(bus.busy), 32'd0);
    chk("midreset_resp_valid", 32'(bus.respValid), 32'd0);
    chk("midreset_div_start", 32'(bus.divStart), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    resetN = 1'b1;
    fixed_lat = 0;
    for (int i = 0; i < NR; i++) new_req(i);
    #1;
    wait_grant(5);
    chk("grant_after_reset", 32'(bus.reqReady), 32'h1);
    drain(100);

    // Random traffic with random response backpressure
    rand_req = 1; rr_random = 1;
    repeat (500) step();
    drain(400);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
